usb_txn_ctrl: RTL and testbench

Host-side USB transaction sequencer that drives the outbound packet pipeline (token/data/handshake encoder chain) and consumes the inbound pipeline's decoded packet flags.
- Converts one upper-layer request into a full OUT or IN transaction: token, then data, then handshake.
- Applies a response timeout and a bounded retry policy.
- Sits between the host command layer and the pipeOut/pipeIn pair; owns bus-direction control.

---
 rtl/usb_pkg.sv | 31 +++
 rtl/usb_txn_ctrl_if.sv | 44 ++++
 rtl/usb_txn_timer.sv | 25 ++
 rtl/usb_txn_ctrl.sv | 177 +++++++++++++++++
 tb/tb_usb_txn_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared types and widths for the host-side USB transaction sequencer.
package usb_pkg;

  localparam int ADDR_W = 7;
  localparam int ENDP_W = 4;
  localparam int DATA_W = 64;
  localparam int PID_W  = 4;

  typedef enum logic [PID_W-1:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_TOKEN_WAIT,
    ST_DATA,
    ST_DATA_WAIT,
    ST_RX_HS,
    ST_RX_DATA,
    ST_HS_SEND,
    ST_HS_WAIT,
    ST_RETRY,
    ST_FINISH
  } txn_state_t;

endpackage

// File: rtl/usb_txn_ctrl_if.sv
// Command, outbound-pipeline and inbound-pipeline signals of the sequencer.
// slave = sequencer view, master = host/pipeline view.
interface usb_txn_ctrl_if;
  import usb_pkg::*;

  logic              txn_start;
  logic              txn_is_in;
  logic [ADDR_W-1:0] txn_addr;
  logic [ENDP_W-1:0] txn_endp;
  logic [DATA_W-1:0] txn_data_out;
  logic              txn_busy;
  logic              txn_done;
  logic              txn_success;
  logic [DATA_W-1:0] txn_data_in;

  logic              out_pktready;
  logic [PID_W-1:0]  out_pid;
  logic [ADDR_W-1:0] out_addr;
  logic [ENDP_W-1:0] out_endp;
  logic [DATA_W-1:0] out_data;
  logic              out_done;

  logic              in_enable;
  logic              in_pktready;
  logic              in_ack;
  logic              in_nak;
  logic              in_error;
  logic [DATA_W-1:0] in_data;

  modport slave (
    input  txn_start, txn_is_in, txn_addr, txn_endp, txn_data_out,
    input  out_done, in_pktready, in_ack, in_nak, in_error, in_data,
    output txn_busy, txn_done, txn_success, txn_data_in,
    output out_pktready, out_pid, out_addr, out_endp, out_data, in_enable
  );

  modport master (
    output txn_start, txn_is_in, txn_addr, txn_endp, txn_data_out,
    output out_done, in_pktready, in_ack, in_nak, in_error, in_data,
    input  txn_busy, txn_done, txn_success, txn_data_in,
    input  out_pktready, out_pid, out_addr, out_endp, out_data, in_enable
  );

endinterface

// File: rtl/usb_txn_timer.sv
// Response timer: counts cycles while enabled, expires on the last of TIMEOUT cycles.
module usb_txn_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_L,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count up while waiting; cleared whenever the sequencer is not listening.
  always_ff @(posedge clk) begin
    if (!rst_L || clear) count <= '0;
    else if (enable)     count <= count + CNT_W'(1);
  end

  assign expired = enable && (count == TERM);

endmodule

// File: rtl/usb_txn_ctrl.sv
// Host transaction sequencer: token, data, handshake with timeout and retry.
//
// state       | meaning
// IDLE        | waiting for txn_start
// TOKEN       | OUT/IN token pulse on out_pktready
// TOKEN_WAIT  | token being sent, wait for out_done
// DATA        | DATA0 pulse with latched payload (OUT only)
// DATA_WAIT   | data being sent, wait for out_done
// RX_HS       | bus released, wait for device handshake (OUT)
// RX_DATA     | bus released, wait for device data (IN)
// HS_SEND     | ACK/NAK pulse to device (IN)
// HS_WAIT     | handshake being sent, wait for out_done
// RETRY       | count the failed attempt, retry or give up
// FINISH      | txn_done pulse with result
module usb_txn_ctrl
  import usb_pkg::*;
#(
  parameter int TIMEOUT      = 255,
  parameter int MAX_ATTEMPTS = 8,
  parameter int CNT_W        = 8
) (
  input logic          clk,
  input logic          rst_L,
  usb_txn_ctrl_if.slave bus
);

  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [ATT_W-1:0] LAST_ATT = ATT_W'(MAX_ATTEMPTS - 1);

  txn_state_t        state;
  logic [ATT_W-1:0]  attempt;
  logic              is_in_q;
  logic              busy_q;
  logic              done_q;
  logic              success_q;
  logic [DATA_W-1:0] data_in_q;
  logic              pktready_q;
  logic [PID_W-1:0]  pid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ENDP_W-1:0] endp_q;
  logic [DATA_W-1:0] data_q;
  logic              in_en_q;
  logic              rx_state;
  logic              expired;

  assign rx_state = (state == ST_RX_HS) || (state == ST_RX_DATA);

  usb_txn_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_L   (rst_L),
    .clear   (!rx_state),
    .enable  (rx_state),
    .expired (expired)
  );

  // Sequencer with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state      <= ST_IDLE;
      attempt    <= '0;
      is_in_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
      data_in_q  <= '0;
      pktready_q <= 1'b0;
      pid_q      <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      data_q     <= '0;
      in_en_q    <= 1'b0;
    end else begin
      pktready_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.txn_start) begin
            is_in_q    <= bus.txn_is_in;
            addr_q     <= bus.txn_addr;
            endp_q     <= bus.txn_endp;
            data_q     <= bus.txn_data_out;
            attempt    <= '0;
            busy_q     <= 1'b1;
            pid_q      <= bus.txn_is_in ? PID_IN : PID_OUT;
            pktready_q <= 1'b1;
            state      <= ST_TOKEN;
          end
        end
        ST_TOKEN: state <= ST_TOKEN_WAIT;
        ST_TOKEN_WAIT: begin
          if (bus.out_done) begin
            if (is_in_q) begin
              in_en_q <= 1'b1;
              state   <= ST_RX_DATA;
            end else begin
              pid_q      <= PID_DATA0;
              pktready_q <= 1'b1;
              state      <= ST_DATA;
            end
          end
        end
        ST_DATA: state <= ST_DATA_WAIT;
        ST_DATA_WAIT: begin
          if (bus.out_done) begin
            in_en_q <= 1'b1;
            state   <= ST_RX_HS;
          end
        end
        ST_RX_HS: begin
          // A corrupted packet cannot be trusted as an ACK, even if flagged as one.
          if (bus.in_error || bus.in_nak || (!bus.in_ack && expired)) begin
            in_en_q <= 1'b0;
            state   <= ST_RETRY;
          end else if (bus.in_ack) begin
            in_en_q   <= 1'b0;
            done_q    <= 1'b1;
            success_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= ST_FINISH;
          end
        end
        ST_RX_DATA: begin
          if (bus.in_pktready) begin
            in_en_q    <= 1'b0;
            pktready_q <= 1'b1;
            pid_q      <= bus.in_error ? PID_NAK : PID_ACK;
            if (!bus.in_error) data_in_q <= bus.in_data;
            state      <= ST_HS_SEND;
          end else if (bus.in_nak || expired) begin
            in_en_q <= 1'b0;
            state   <= ST_RETRY;
          end
        end
        ST_HS_SEND: state <= ST_HS_WAIT;
        ST_HS_WAIT: begin
          if (bus.out_done) begin
            if (pid_q == PID_ACK) begin
              done_q    <= 1'b1;
              success_q <= 1'b1;
              busy_q    <= 1'b0;
              state     <= ST_FINISH;
            end else begin
              state <= ST_RETRY;
            end
          end
        end
        ST_RETRY: begin
          if (attempt == LAST_ATT) begin
            done_q    <= 1'b1;
            success_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= ST_FINISH;
          end else begin
            attempt    <= attempt + ATT_W'(1);
            pid_q      <= is_in_q ? PID_IN : PID_OUT;
            pktready_q <= 1'b1;
            state      <= ST_TOKEN;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.txn_busy     = busy_q;
  assign bus.txn_done     = done_q;
  assign bus.txn_success  = success_q;
  assign bus.txn_data_in  = data_in_q;
  assign bus.out_pktready = pktready_q;
  assign bus.out_pid      = pid_q;
  assign bus.out_addr     = addr_q;
  assign bus.out_endp     = endp_q;
  assign bus.out_data     = data_q;
  assign bus.in_enable    = in_en_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Bench for usb_txn_ctrl: a scripted device/pipeline whose expected waveform
// is derived cycle by cycle from the transaction rules, checked every cycle.
module tb_usb_txn_ctrl;
  import usb_pkg::*;

  localparam int TO   = 255;
  localparam int MAXA = 8;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  always #5 clk = ~clk;

  usb_txn_ctrl_if bus();

  usb_txn_ctrl #(.TIMEOUT(TO), .MAX_ATTEMPTS(MAXA), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // expected outputs for the current cycle
  logic        chk_on = 1'b0;
  logic        exp_pktready = 1'b0, exp_in_en = 1'b0, exp_done = 1'b0;
  logic        exp_success = 1'b0, exp_busy = 1'b0;
  logic        chk_fields = 1'b0, chk_data = 1'b0;
  logic [3:0]  exp_pid = '0;
  logic [6:0]  exp_addr = '0;
  logic [3:0]  exp_endp = '0;
  logic [63:0] exp_data = '0, exp_data_in = '0;

  // observations that pin the model with literal expectations
  int          tok_cnt = 0, n_runs = 0, en_run = 0, min_run = 0, max_run = 0;
  logic [63:0] last_data0 = '0, last_done_data = '0;
  logic [3:0]  last_hs_pid = '0;
  logic        last_succ = 1'b0;
  int          nak_sent = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the expected waveform.
  always @(negedge clk) begin
    if (chk_on) begin
      check("out_pktready", bus.out_pktready, exp_pktready);
      check("in_enable", bus.in_enable, exp_in_en);
      check("txn_done", bus.txn_done, exp_done);
      check("txn_busy", bus.txn_busy, exp_busy);
      if (exp_done) begin
        check("txn_success", bus.txn_success, exp_success);
        check("txn_data_in", bus.txn_data_in, exp_data_in);
      end
      if (chk_fields) begin
        check("out_pid", bus.out_pid, exp_pid);
        check("out_addr", bus.out_addr, exp_addr);
        check("out_endp", bus.out_endp, exp_endp);
        if (chk_data) check("out_data", bus.out_data, exp_data);
      end
      if (bus.out_pktready && (bus.out_pid == PID_IN || bus.out_pid == PID_OUT)) tok_cnt++;
      if (bus.out_pktready && bus.out_pid == PID_DATA0) last_data0 = bus.out_data;
      if (bus.out_pktready && (bus.out_pid == PID_ACK || bus.out_pid == PID_NAK)) begin
        last_hs_pid = bus.out_pid;
        if (bus.out_pid == PID_NAK) nak_sent++;
      end
      if (bus.txn_done) begin
        last_succ      = bus.txn_success;
        last_done_data = bus.txn_data_in;
      end
      if (bus.in_enable) en_run++;
      else if (en_run != 0) begin
        n_runs++;
        if (en_run < min_run) min_run = en_run;
        if (en_run > max_run) max_run = en_run;
        en_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.txn_start   = 1'b0;
    bus.out_done    = 1'b0;
    bus.in_pktready = 1'b0;
    bus.in_ack      = 1'b0;
    bus.in_nak      = 1'b0;
    bus.in_error    = 1'b0;
  endtask

  // Events the sequencer must ignore outside its receive windows / IDLE.
  task automatic noise();
    bus.txn_start    = ($urandom_range(0, 3) == 0);
    bus.txn_is_in    = 1'($urandom_range(0, 1));
    bus.txn_addr     = 7'($urandom);
    bus.txn_endp     = 4'($urandom);
    bus.txn_data_out = {$urandom, $urandom};
    bus.in_pktready  = ($urandom_range(0, 5) == 0);
    bus.in_ack       = ($urandom_range(0, 5) == 0);
    bus.in_nak       = ($urandom_range(0, 5) == 0);
    bus.in_error     = ($urandom_range(0, 5) == 0);
    bus.in_data      = {$urandom, $urandom};
    bus.out_done     = 1'b0;
  endtask

  // Current cycle carries the pulse; pipeline answers out_done after 1..4 cycles.
  task automatic send_pkt(input logic [3:0] pid, input logic has_data);
    int dly;
    exp_pktready = 1'b1;
    exp_pid      = pid;
    chk_fields   = 1'b1;
    chk_data     = has_data;
    dly = $urandom_range(1, 4);
    noise();
    tick();
    exp_pktready = 1'b0;
    for (int i = 1; i < dly; i++) begin
      noise();
      tick();
    end
    noise();
    bus.out_done = 1'b1;
    tick();
    quiet();
    chk_fields = 1'b0;
  endtask

  // kind: 0 silence, 1 ACK / clean data, 2 NAK, 3 error (bad data on IN), 4 error+ACK (OUT)
  task automatic window(input logic is_in, input int kind, input int j, input logic [63:0] rd);
    exp_in_en = 1'b1;
    for (int w = 0; w < TO; w++) begin
      quiet();
      bus.in_data = {$urandom, $urandom};
      if (kind != 0 && w == j) begin
        if (is_in) begin
          case (kind)
            1: begin bus.in_pktready = 1'b1; bus.in_data = rd; end
            3: begin bus.in_pktready = 1'b1; bus.in_error = 1'b1; end
            default: bus.in_nak = 1'b1;
          endcase
        end else begin
          case (kind)
            1: bus.in_ack = 1'b1;
            2: bus.in_nak = 1'b1;
            3: bus.in_error = 1'b1;
            default: begin bus.in_ack = 1'b1; bus.in_error = 1'b1; end
          endcase
        end
        tick();
        quiet();
        exp_in_en = 1'b0;
        return;
      end
      tick();
    end
    quiet();
    exp_in_en = 1'b0;
  endtask

  task automatic finish(input logic s);
    exp_done    = 1'b1;
    exp_success = s;
    exp_busy    = 1'b0;
    noise();
    tick();
    quiet();
    exp_done = 1'b0;
  endtask

  // One full transaction starting in an IDLE cycle; ends in the IDLE cycle after FINISH.
  task automatic run_txn(input logic is_in, input logic [6:0] a, input logic [3:0] e,
                         input logic [63:0] d, input int kinds[MAXA], input int js[MAXA]);
    logic [63:0] rd;
    tok_cnt = 0; n_runs = 0; min_run = 1000000; max_run = 0; nak_sent = 0;
    quiet();
    bus.txn_start    = 1'b1;
    bus.txn_is_in    = is_in;
    bus.txn_addr     = a;
    bus.txn_endp     = e;
    bus.txn_data_out = d;
    exp_busy = 1'b0;
    tick();
    quiet();
    exp_busy = 1'b1;
    exp_addr = a;
    exp_endp = e;
    exp_data = d;
    for (int att = 0; att < MAXA; att++) begin
      send_pkt(is_in ? PID_IN : PID_OUT, 1'b0);
      if (!is_in) begin
        send_pkt(PID_DATA0, 1'b1);
        window(1'b0, kinds[att], js[att], '0);
        if (kinds[att] == 1) begin
          finish(1'b1);
          return;
        end
      end else begin
        rd = {$urandom, $urandom};
        window(1'b1, kinds[att], js[att], rd);
        if (kinds[att] == 1) begin
          exp_data_in = rd;
          send_pkt(PID_ACK, 1'b0);
          finish(1'b1);
          return;
        end
        if (kinds[att] == 3) send_pkt(PID_NAK, 1'b0);
      end
      noise();
      tick();
    end
    finish(1'b0);
  endtask

  task automatic set_plan(output int k[MAXA], output int j[MAXA], input int k0, input int k1,
                          input int k2, input int j0);
    for (int i = 0; i < MAXA; i++) begin k[i] = 0; j[i] = j0; end
    k[0] = k0; k[1] = k1; k[2] = k2;
  endtask

  // IN transaction whose single attempt returns rd cleanly at window cycle jj.
  task automatic run_in_fixed(input logic [6:0] a, input logic [63:0] rd_fixed, input int jj);
    tok_cnt = 0; nak_sent = 0;
    quiet();
    bus.txn_start = 1'b1; bus.txn_is_in = 1'b1; bus.txn_addr = a;
    bus.txn_endp = 4'h2; bus.txn_data_out = '0;
    exp_busy = 1'b0;
    tick();
    quiet();
    exp_busy = 1'b1; exp_addr = a; exp_endp = 4'h2; exp_data = '0;
    send_pkt(PID_IN, 1'b0);
    window(1'b1, 1, jj, rd_fixed);
    exp_data_in = rd_fixed;
    send_pkt(PID_ACK, 1'b0);
    finish(1'b1);
  endtask

  initial begin
    int k[MAXA];
    int j[MAXA];
    logic is_in;
    quiet();
    bus.txn_is_in = 1'b0; bus.txn_addr = '0; bus.txn_endp = '0;
    bus.txn_data_out = '0; bus.in_data = '0;

    // reset state: every output 0
    rst_L = 1'b0;
    tick();
    chk_on = 1'b1; chk_fields = 1'b1; chk_data = 1'b1;
    tick(); tick();
    rst_L = 1'b1;
    tick();
    chk_fields = 1'b0; chk_data = 1'b0;

    // OUT, ACK on first attempt
    set_plan(k, j, 1, 0, 0, 3);
    run_txn(1'b0, 7'h05, 4'h1, 64'hDEADBEEF_01234567, k, j);
    check("t1_tokens", tok_cnt, 1);
    check("t1_payload", last_data0, 64'hDEADBEEF_01234567);
    check("t1_success", last_succ, 1);

    // IN, clean data, ACK sent
    run_in_fixed(7'h12, 64'hCAFE_F00D_0000_0001, 5);
    check("t2_data_in", last_done_data, 64'hCAFE_F00D_0000_0001);
    check("t2_hs_pid", last_hs_pid, 4'b0010);
    check("t2_success", last_succ, 1);

    // OUT, NAK NAK ACK
    set_plan(k, j, 2, 2, 1, 1);
    run_txn(1'b0, 7'h33, 4'h7, 64'h0123_4567_89AB_CDEF, k, j);
    check("t3_tokens", tok_cnt, 3);
    check("t3_success", last_succ, 1);

    // IN, device silent on every attempt
    set_plan(k, j, 0, 0, 0, 0);
    run_txn(1'b1, 7'h21, 4'h3, '0, k, j);
    check("t4_tokens", tok_cnt, 8);
    check("t4_windows", n_runs, 8);
    check("t4_min_wait", min_run, 255);
    check("t4_max_wait", max_run, 255);
    check("t4_success", last_succ, 0);
    check("t4_data_kept", last_done_data, 64'hCAFE_F00D_0000_0001);

    // IN, bad data then clean
    set_plan(k, j, 3, 1, 0, 2);
    run_txn(1'b1, 7'h44, 4'h5, '0, k, j);
    check("t5_naks", nak_sent, 1);
    check("t5_hs_pid", last_hs_pid, 4'b0010);
    check("t5_tokens", tok_cnt, 2);
    check("t5_success", last_succ, 1);

    // OUT, ACK and error together count as error
    set_plan(k, j, 4, 1, 0, 0);
    run_txn(1'b0, 7'h0A, 4'hB, 64'h5555_AAAA_5555_AAAA, k, j);
    check("t6_tokens", tok_cnt, 2);
    check("t6_success", last_succ, 1);

    // OUT, ACK on the expiry cycle beats the timeout
    set_plan(k, j, 1, 0, 0, 254);
    run_txn(1'b0, 7'h7F, 4'hF, 64'hFFFF_0000_FFFF_0000, k, j);
    check("t7_tokens", tok_cnt, 1);
    check("t7_success", last_succ, 1);

    // reset while waiting for the data packet to finish
    quiet();
    bus.txn_start = 1'b1; bus.txn_is_in = 1'b0; bus.txn_addr = 7'h09;
    bus.txn_endp = 4'h4; bus.txn_data_out = 64'h1111_2222_3333_4444;
    tick();
    quiet();
    exp_busy = 1'b1; exp_addr = 7'h09; exp_endp = 4'h4; exp_data = 64'h1111_2222_3333_4444;
    send_pkt(PID_OUT, 1'b0);
    exp_pktready = 1'b1; exp_pid = PID_DATA0; chk_fields = 1'b1; chk_data = 1'b1;
    tick();
    exp_pktready = 1'b0;
    rst_L = 1'b0;
    tick();
    rst_L = 1'b1;
    exp_busy = 1'b0; exp_data_in = '0;
    exp_pid = '0; exp_addr = '0; exp_endp = '0; exp_data = '0;
    check("rst_data_in", bus.txn_data_in, 64'h0);
    check("rst_busy", bus.txn_busy, 0);
    tick();
    chk_fields = 1'b0; chk_data = 1'b0;
    set_plan(k, j, 1, 0, 0, 0);
    run_txn(1'b0, 7'h0C, 4'h6, 64'hABCD_EF01_2345_6789, k, j);
    check("t8_tokens", tok_cnt, 1);
    check("t8_success", last_succ, 1);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      int r;
      is_in = 1'($urandom_range(0, 1));
      for (int i = 0; i < MAXA; i++) begin
        r = $urandom_range(0, 9);
        k[i] = (r == 0) ? 0 : (r < 4) ? 1 : (r < 7) ? 2 : (r < 9) ? 3 : 4;
        j[i] = ($urandom_range(0, 9) == 0) ? 254 : $urandom_range(0, 6);
      end
      run_txn(is_in, 7'($urandom), 4'($urandom), {$urandom, $urandom}, k, j);
      repeat ($urandom_range(0, 3)) begin
        quiet();
        tick();
      end
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
